// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard unit.
// This covers the operand-select encoding, the multi-cycle FSM states and the width helpers.
package fwd_pkg;

   localparam int SEL_RF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_t;

   // Select code for "stage-0 load data"; it sits just past the last ALU-result code.
   function automatic int sel_load(input int fwd_stages);
      return fwd_stages + 1;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle of EX-stage request, downstream-stage state and hazard-unit responses.
// The pipeline is the master and the hazard unit is the slave.
interface fwd_hazard_scoreboard_if #(
   parameter int FWD_STAGES = 3,
   parameter int REG_AW     = 5,
   parameter int MAX_LAT    = 8
);
   localparam int LAT_W = fwd_pkg::clog2(MAX_LAT + 1);
   localparam int SELW  = fwd_pkg::clog2(FWD_STAGES + 2);

   logic                         ex_valid;
   logic [REG_AW-1:0]            ex_rs1;
   logic [REG_AW-1:0]            ex_rs2;
   logic                         ex_rs1_used;
   logic                         ex_rs2_used;
   logic [REG_AW-1:0]            ex_rd;
   logic                         ex_we;
   logic                         ex_mc;
   logic [LAT_W-1:0]             ex_lat;
   logic [FWD_STAGES*REG_AW-1:0] st_rd;
   logic [FWD_STAGES-1:0]        st_we;
   logic                         st_load;

   logic [SELW-1:0]              rs1_sel;
   logic [SELW-1:0]              rs2_sel;
   logic                         stall;
   logic                         mc_done;
   logic [REG_AW-1:0]            mc_rd;

   modport master (
      output ex_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
      output ex_rd, ex_we, ex_mc, ex_lat, st_rd, st_we, st_load,
      input  rs1_sel, rs2_sel, stall, mc_done, mc_rd
   );

   modport slave (
      input  ex_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
      input  ex_rd, ex_we, ex_mc, ex_lat, st_rd, st_we, st_load,
      output rs1_sel, rs2_sel, stall, mc_done, mc_rd
   );

endinterface

// File: rtl/fwd_hazard_scoreboard_src_select.sv
// Priority match of one EX source register against the downstream stage destinations.
// The nearest stage wins, and a stage-0 load match selects the load-data leg.
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int FWD_STAGES = 3,
   parameter int REG_AW     = 5,
   parameter int SELW       = 3
) (
   input  logic                         valid,
   input  logic                         used,
   input  logic [REG_AW-1:0]            rs,
   input  logic [FWD_STAGES*REG_AW-1:0] st_rd,
   input  logic [FWD_STAGES-1:0]        st_we,
   input  logic                         st_load,
   output logic [SELW-1:0]              sel
);

   logic [FWD_STAGES-1:0] hit;

   generate
      for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_hit
         assign hit[gi] = st_we[gi]
                       && (st_rd[gi*REG_AW +: REG_AW] == rs)
                       && (st_rd[gi*REG_AW +: REG_AW] != '0);
      end
   endgenerate

   // Scan farthest to nearest so the lowest matching index overwrites the result last.
   always_comb begin
      sel = SELW'(SEL_RF);
      if (valid && used && (rs != '0)) begin
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
               if ((k == 0) && st_load) sel = SELW'(sel_load(FWD_STAGES));
               else                     sel = SELW'(k + 1);
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// EX-stage forwarding selects plus a single-entry multi-cycle scoreboard.
// It raises stall on RAW, WAW or structural conflicts with the in-flight op.
module fwd_hazard_scoreboard
   import fwd_pkg::*;
#(
   parameter int FWD_STAGES = 3,
   parameter int REG_AW     = 5,
   parameter int MAX_LAT    = 8,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   fwd_hazard_scoreboard_if.slave bus,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam int LAT_W = clog2(MAX_LAT + 1);
   localparam int SELW  = clog2(FWD_STAGES + 2);

   mc_state_t         state_reg, state_next;
   logic [LAT_W-1:0]  count_reg, count_next;
   logic [REG_AW-1:0] mc_rd_reg, mc_rd_next;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic [LAT_W-1:0]  lat_clamped;
   logic              mc_active;
   logic              raw_hit, waw_hit, struct_hit;
   logic              stall_int;

   fwd_src_select #(
      .FWD_STAGES (FWD_STAGES),
      .REG_AW     (REG_AW),
      .SELW       (SELW)
   ) u_rs1_sel (
      .valid   (bus.ex_valid),
      .used    (bus.ex_rs1_used),
      .rs      (bus.ex_rs1),
      .st_rd   (bus.st_rd),
      .st_we   (bus.st_we),
      .st_load (bus.st_load),
      .sel     (bus.rs1_sel)
   );

   fwd_src_select #(
      .FWD_STAGES (FWD_STAGES),
      .REG_AW     (REG_AW),
      .SELW       (SELW)
   ) u_rs2_sel (
      .valid   (bus.ex_valid),
      .used    (bus.ex_rs2_used),
      .rs      (bus.ex_rs2),
      .st_rd   (bus.st_rd),
      .st_we   (bus.st_we),
      .st_load (bus.st_load),
      .sel     (bus.rs2_sel)
   );

   always_comb begin
      lat_clamped = bus.ex_lat;
      if (bus.ex_lat == '0)                      lat_clamped = LAT_W'(1);
      else if (bus.ex_lat > LAT_W'(MAX_LAT))     lat_clamped = LAT_W'(MAX_LAT);
   end

   // The regfile is not write-through, so DONE still blocks readers of mc_rd.
   assign mc_active  = (state_reg != IDLE);
   assign raw_hit    = mc_active && (mc_rd_reg != '0)
                    && ((bus.ex_rs1_used && (bus.ex_rs1 == mc_rd_reg))
                     || (bus.ex_rs2_used && (bus.ex_rs2 == mc_rd_reg)));
   assign waw_hit    = mc_active && (mc_rd_reg != '0) && bus.ex_we
                    && (bus.ex_rd == mc_rd_reg);
   assign struct_hit = mc_active && bus.ex_mc;
   assign stall_int  = bus.ex_valid && (raw_hit || waw_hit || struct_hit);

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      mc_rd_next = mc_rd_reg;
      case (state_reg)
         IDLE: begin
            if (bus.ex_valid && bus.ex_mc && !stall_int) begin
               state_next = BUSY;
               count_next = lat_clamped - LAT_W'(1);
               mc_rd_next = bus.ex_rd;
            end
         end
         BUSY: begin
            if (count_reg == '0) state_next = DONE;
            else                 count_next = count_reg - LAT_W'(1);
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         mc_rd_reg     <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         mc_rd_reg <= mc_rd_next;
         if (stall_int && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

   assign bus.stall   = stall_int;
   assign bus.mc_done = (state_reg == DONE);
   assign bus.mc_rd   = mc_rd_reg;
   assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard: a forwarding vector table, then multi-cycle
// scoreboard sequences covering latency, hazards, reset and counter saturation.
module tb_fwd_hazard_scoreboard;

   localparam int FS = 3;
   localparam int AW = 5;
   localparam int ML = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   fwd_hazard_scoreboard_if #(.FWD_STAGES(FS), .REG_AW(AW), .MAX_LAT(ML)) bus ();

   fwd_hazard_scoreboard #(
      .FWD_STAGES (FS),
      .REG_AW     (AW),
      .MAX_LAT    (ML),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          valid;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic          u1;
      logic          u2;
      logic [14:0]   st_rd;
      logic [2:0]    st_we;
      logic          st_load;
      int            exp1;
      int            exp2;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [14:0] pk(input int s0, input int s1, input int s2);
      return {5'(s2), 5'(s1), 5'(s0)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s: %0d", name, act);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.ex_valid    = 1'b0;
      bus.ex_rs1      = '0;
      bus.ex_rs2      = '0;
      bus.ex_rs1_used = 1'b0;
      bus.ex_rs2_used = 1'b0;
      bus.ex_rd       = '0;
      bus.ex_we       = 1'b0;
      bus.ex_mc       = 1'b0;
      bus.ex_lat      = '0;
      bus.st_rd       = '0;
      bus.st_we       = '0;
      bus.st_load     = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic issue_mc(input int rd, input int lat);
      clear_inputs();
      bus.ex_valid = 1'b1;
      bus.ex_mc    = 1'b1;
      bus.ex_we    = 1'b1;
      bus.ex_rd    = AW'(rd);
      bus.ex_lat   = 4'(lat);
   endtask

   task automatic set_reader(input int rs1, input int rs2, input int rd);
      clear_inputs();
      bus.ex_valid    = 1'b1;
      bus.ex_rs1      = AW'(rs1);
      bus.ex_rs2      = AW'(rs2);
      bus.ex_rs1_used = 1'b1;
      bus.ex_rs2_used = 1'b1;
      bus.ex_rd       = AW'(rd);
      bus.ex_we       = 1'b1;
   endtask

   initial begin
      bit seen_done;

      //            valid rs1 rs2 u1 u2 st_rd         we      load  e1 e2
      vecs[0] = '{1'b1, 5,  7, 1, 1, pk(5, 5, 7), 3'b011, 1'b0, 1, 0};
      vecs[1] = '{1'b1, 5,  7, 1, 1, pk(5, 5, 7), 3'b111, 1'b0, 1, 3};
      vecs[2] = '{1'b1, 5,  1, 1, 1, pk(1, 5, 5), 3'b111, 1'b0, 2, 1};
      vecs[3] = '{1'b1, 9,  9, 1, 1, pk(9, 9, 9), 3'b110, 1'b1, 2, 2};
      vecs[4] = '{1'b1, 9,  9, 1, 1, pk(9, 0, 0), 3'b001, 1'b1, 4, 4};
      vecs[5] = '{1'b1, 9,  9, 1, 0, pk(9, 0, 0), 3'b001, 1'b1, 4, 0};
      vecs[6] = '{1'b1, 0,  0, 1, 1, pk(0, 0, 0), 3'b111, 1'b0, 0, 0};
      vecs[7] = '{1'b0, 5,  5, 1, 1, pk(5, 5, 5), 3'b111, 1'b0, 0, 0};
      vecs[8] = '{1'b1, 6,  5, 1, 1, pk(5, 5, 5), 3'b100, 1'b0, 0, 3};
      vecs[9] = '{1'b1, 9,  9, 1, 1, pk(9, 9, 9), 3'b001, 1'b0, 1, 1};

      // Reset state
      reset_dut();
      @(negedge clk);
      chk("reset_rs1_sel", int'(bus.rs1_sel), 0);
      chk("reset_stall", int'(bus.stall), 0);
      chk("reset_mc_done", int'(bus.mc_done), 0);
      chk("reset_mc_rd", int'(bus.mc_rd), 0);
      chk("reset_stall_cnt", int'(stall_cnt), 0);

      // Forwarding table (FSM idle, so stall must stay low)
      for (int i = 0; i < 10; i++) begin
         clear_inputs();
         bus.ex_valid    = vecs[i].valid;
         bus.ex_rs1      = vecs[i].rs1;
         bus.ex_rs2      = vecs[i].rs2;
         bus.ex_rs1_used = vecs[i].u1;
         bus.ex_rs2_used = vecs[i].u2;
         bus.st_rd       = vecs[i].st_rd;
         bus.st_we       = vecs[i].st_we;
         bus.st_load     = vecs[i].st_load;
         #1;
         chk($sformatf("vec%0d_rs1_sel", i), int'(bus.rs1_sel), vecs[i].exp1);
         chk($sformatf("vec%0d_rs2_sel", i), int'(bus.rs2_sel), vecs[i].exp2);
         chk($sformatf("vec%0d_stall", i), int'(bus.stall), 0);
      end

      // T3: lat 4 on x3, dependent reader from cycle 1
      reset_dut();
      issue_mc(3, 4);
      @(negedge clk);
      chk("t3_c0_stall", int'(bus.stall), 0);
      next_cycle();
      set_reader(3, 0, 10);
      bus.ex_rs2_used = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk($sformatf("t3_c%0d_stall", c), int'(bus.stall), (c <= 5) ? 1 : 0);
         chk($sformatf("t3_c%0d_mc_done", c), int'(bus.mc_done), (c == 5) ? 1 : 0);
         if (c == 5) chk("t3_c5_mc_rd", int'(bus.mc_rd), 3);
         if (c < 6) next_cycle();
      end
      chk("t3_rs1_sel_after", int'(bus.rs1_sel), 0);
      chk("t3_stall_cnt", int'(stall_cnt), 5);

      // T4: structural, WAW and an independent op while busy
      reset_dut();
      issue_mc(3, 8);
      next_cycle();
      clear_inputs();
      bus.ex_valid = 1'b1;
      bus.ex_mc    = 1'b1;
      bus.ex_lat   = 4'd2;
      @(negedge clk);
      chk("t4_struct_stall", int'(bus.stall), 1);
      next_cycle();
      clear_inputs();
      bus.ex_valid = 1'b1;
      bus.ex_we    = 1'b1;
      bus.ex_rd    = 5'd3;
      @(negedge clk);
      chk("t4_waw_stall", int'(bus.stall), 1);
      next_cycle();
      set_reader(1, 2, 4);
      @(negedge clk);
      chk("t4_indep_stall", int'(bus.stall), 0);

      // mc op targeting x0: only the structural term may fire
      reset_dut();
      issue_mc(0, 3);
      next_cycle();
      set_reader(0, 0, 0);
      @(negedge clk);
      chk("x0_raw_waw_stall", int'(bus.stall), 0);
      bus.ex_mc = 1'b1;
      #1;
      chk("x0_struct_stall", int'(bus.stall), 1);

      // T5: latency clamping
      reset_dut();
      issue_mc(3, 0);
      next_cycle();
      clear_inputs();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("t5_lat0_c%0d_mc_done", c), int'(bus.mc_done), (c == 2) ? 1 : 0);
         next_cycle();
      end
      reset_dut();
      issue_mc(3, 15);
      next_cycle();
      clear_inputs();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("t5_lat15_c%0d_mc_done", c), int'(bus.mc_done), (c == 9) ? 1 : 0);
         next_cycle();
      end

      // T6: reset while busy drops the op
      reset_dut();
      issue_mc(3, 8);
      next_cycle();
      set_reader(3, 0, 10);
      @(negedge clk);
      chk("t6_busy_stall", int'(bus.stall), 1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_after_rst_stall", int'(bus.stall), 0);
      chk("t6_after_rst_cnt", int'(stall_cnt), 0);
      seen_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.mc_done) seen_done = 1'b1;
         next_cycle();
      end
      chk("t6_no_mc_done", int'(seen_done), 0);

      // T7: back-to-back lat-8 ops give 27 stall cycles in 30; 4-bit counter saturates
      reset_dut();
      issue_mc(3, 8);
      for (int c = 0; c < 30; c++) next_cycle();
      @(negedge clk);
      chk("t7_stall_cnt_sat", int'(stall_cnt), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
